// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and an external
// combinational adder. The slave side is the arbiter; the master side
// stands for everything around it (requesters, response sink and adder).
interface alu_arbiter_if #(
    parameter int DW = 8
);
    logic          req0_valid;
    logic          req1_valid;
    logic [DW-1:0] req0_a;
    logic [DW-1:0] req0_b;
    logic [DW-1:0] req1_a;
    logic [DW-1:0] req1_b;
    logic          req0_ready;
    logic          req1_ready;
    logic          rsp0_valid;
    logic          rsp1_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_ready;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic          busy;
    logic          grant_id;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  rsp_ready, alu_res,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_a, alu_b, busy, grant_id
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output rsp_ready, alu_res,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_a, alu_b, busy, grant_id
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared external adder.
// One operation at a time: IDLE (accept) -> EXEC (adder sees operands,
// sum captured) -> RESP (result held until the granted requester takes it).
module alu_arbiter #(
    parameter int DW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          last_grant_q;
    logic          grant_id_q;
    logic [DW-1:0] op_a_q;
    logic [DW-1:0] op_b_q;
    logic [DW-1:0] rsp_data_q;

    logic          winner;
    logic          ready0;
    logic          ready1;
    logic          handshake;

    // Arbitration, handshake detection and next-state selection.
    // Readys are masked by rst_n so nothing looks accepted while reset is held.
    always_comb begin
        state_d   = state_q;
        winner    = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        handshake = 1'b0;

        // A tie goes to whoever was not granted last; otherwise the lone requester.
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.req1_valid;
        end

        case (state_q)
            IDLE: begin
                ready0    = rst_n && bus.req0_valid && (winner == 1'b0);
                ready1    = rst_n && bus.req1_valid && (winner == 1'b1);
                handshake = ready0 || ready1;
                if (handshake) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's operands and grant on handshake; the op registers
    // drive the adder directly, so its inputs only move when entering EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q       <= '0;
            op_b_q       <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (handshake) begin
            op_a_q       <= winner ? bus.req1_a : bus.req0_a;
            op_b_q       <= winner ? bus.req1_b : bus.req0_b;
            grant_id_q   <= winner;
            last_grant_q <= winner;
        end
    end

    // Latch the adder result at the end of EXEC; it stays put through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
        end else if (state_q == EXEC) begin
            rsp_data_q <= bus.alu_res;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp0_valid = (state_q == RESP) && (grant_id_q == 1'b0);
    assign bus.rsp1_valid = (state_q == RESP) && (grant_id_q == 1'b1);
    assign bus.rsp_data   = rsp_data_q;
    assign bus.alu_a      = op_a_q;
    assign bus.alu_b      = op_b_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_id   = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: external adder modelled as a
// combinational sum, expected values hand-computed per step.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_arbiter_if #(.DW(8)) bus ();

    assign bus.alu_res = bus.alu_a + bus.alu_b;

    alu_arbiter #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_a = 8'd0;
        bus.req0_b = 8'd0;
        bus.req1_a = 8'd0;
        bus.req1_b = 8'd0;
        bus.rsp_ready = 1'b1;

        // Reset state (req0_valid high to see ready is masked in reset)
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);
        chk("rst_rsp0", bus.rsp0_valid, 0);
        chk("rst_rsp1", bus.rsp1_valid, 0);
        chk("rst_data", bus.rsp_data, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        bus.req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // req0 alone: 3 + 4
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd4;
        #1;
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("t1_exec_busy", bus.busy, 1);
        chk("t1_exec_ready0", bus.req0_ready, 0);
        chk("t1_exec_alu_a", bus.alu_a, 3);
        chk("t1_exec_alu_b", bus.alu_b, 4);
        chk("t1_exec_rsp0", bus.rsp0_valid, 0);
        tick();
        chk("t1_rsp0", bus.rsp0_valid, 1);
        chk("t1_rsp1", bus.rsp1_valid, 0);
        chk("t1_data", bus.rsp_data, 7);
        chk("t1_gid", bus.grant_id, 0);
        tick();
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_idle_rsp0", bus.rsp0_valid, 0);
        chk("t1_hold_alu_a", bus.alu_a, 3);

        // req1 alone: 200 + 100 wraps to 44
        bus.req1_valid = 1'b1; bus.req1_a = 8'd200; bus.req1_b = 8'd100;
        #1;
        chk("t2_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        chk("t2_exec_gid", bus.grant_id, 1);
        tick();
        chk("t2_rsp1", bus.rsp1_valid, 1);
        chk("t2_rsp0", bus.rsp0_valid, 0);
        chk("t2_data", bus.rsp_data, 44);
        tick();
        chk("t2_idle_busy", bus.busy, 0);

        // Fresh reset, then both valid: req0 first, req1 second, tie back to req0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_b = 8'd1;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd2; bus.req1_b = 8'd2;
        #1;
        chk("t3_ready0", bus.req0_ready, 1);
        chk("t3_ready1", bus.req1_ready, 0);
        tick();
        chk("t3_exec_ready1", bus.req1_ready, 0);
        tick();
        chk("t3_rsp0", bus.rsp0_valid, 1);
        chk("t3_data0", bus.rsp_data, 2);
        chk("t3_resp_ready1", bus.req1_ready, 0);
        tick();
        chk("t3_rr_ready1", bus.req1_ready, 1);
        chk("t3_rr_ready0", bus.req0_ready, 0);
        tick();
        tick();
        chk("t3_rsp1", bus.rsp1_valid, 1);
        chk("t3_data1", bus.rsp_data, 4);
        tick();
        chk("t3_tie_ready0", bus.req0_ready, 1);
        chk("t3_tie_ready1", bus.req1_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        chk("t3_drop_busy", bus.busy, 0);

        // RESP stall: rsp_ready low for 5 cycles, req1 waiting
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd5; bus.req0_b = 8'd6;
        #1;
        chk("t4_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd20; bus.req1_b = 8'd30;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_rsp0", bus.rsp0_valid, 1);
            chk("t4_stall_data", bus.rsp_data, 11);
            chk("t4_stall_busy", bus.busy, 1);
            chk("t4_stall_ready0", bus.req0_ready, 0);
            chk("t4_stall_ready1", bus.req1_ready, 0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        chk("t4_release_busy", bus.busy, 0);
        chk("t4_release_ready1", bus.req1_ready, 1);
        bus.req1_valid = 1'b0;
        tick();
        chk("t4_drop_busy", bus.busy, 0);

        // Reset during EXEC abandons the operation
        bus.req0_valid = 1'b1; bus.req0_a = 8'd50; bus.req0_b = 8'd50;
        tick();
        chk("t5_exec_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_alu_a", bus.alu_a, 0);
        chk("t5_rst_data", bus.rsp_data, 0);
        chk("t5_rst_ready0", bus.req0_ready, 0);
        chk("t5_rst_rsp0", bus.rsp0_valid, 0);
        tick();
        tick();
        chk("t5_hold_rsp0", bus.rsp0_valid, 0);
        chk("t5_hold_busy", bus.busy, 0);
        rst_n = 1'b1;
        bus.req0_a = 8'd9; bus.req0_b = 8'd9;
        #1;
        chk("t5_after_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        chk("t5_after_rsp0", bus.rsp0_valid, 1);
        chk("t5_after_data", bus.rsp_data, 18);
        tick();

        // req1 streaming back-to-back; req0 joins and wins the next tie
        bus.req1_valid = 1'b1; bus.req1_a = 8'd10; bus.req1_b = 8'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_ready1", bus.req1_ready, 1);
            chk("t6_ready0", bus.req0_ready, 0);
            tick();
            chk("t6_exec_busy", bus.busy, 1);
            chk("t6_exec_gid", bus.grant_id, 1);
            if (i == 2) begin
                bus.req0_valid = 1'b1; bus.req0_a = 8'd7; bus.req0_b = 8'd7;
            end
            tick();
            chk("t6_rsp1", bus.rsp1_valid, 1);
            chk("t6_data", bus.rsp_data, 11);
            tick();
        end
        #1;
        chk("t6_tie_ready0", bus.req0_ready, 1);
        chk("t6_tie_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        chk("t6_gid0", bus.grant_id, 0);
        chk("t6_alu_a", bus.alu_a, 7);
        tick();
        chk("t6_rsp0", bus.rsp0_valid, 1);
        chk("t6_data0", bus.rsp_data, 14);
        tick();
        chk("t6_back_ready1", bus.req1_ready, 1);
        bus.req1_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
